// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters encoder channels A/B, decodes Gray-code
// phase changes into step/dir pulses, counts illegal transitions and measures the step period.
module quad_decoder #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                a_in,
  input  logic                b_in,
  output logic                step,
  output logic                dir,
  output logic                err,
  output logic [15:0]         err_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam logic [7:0]          FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [0:0]          ST_INIT   = 1'b0;
  localparam logic [0:0]          ST_RUN    = 1'b1;
  localparam logic [PERIOD_W-1:0] CYC_MAX   = '1;

  logic [1:0]          a_sync_q, b_sync_q;
  logic [1:0]          sync;
  logic [1:0]          filt_q, filt_d;
  logic [7:0]          fcnt_q [2];
  logic [7:0]          fcnt_d [2];
  logic [0:0]          state_q, state_d;
  logic [1:0]          init_cnt_q, init_cnt_d;
  logic [1:0]          prev_q;
  logic                step_q, step_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [PERIOD_W-1:0] cyc_q, cyc_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                have_prev_q, have_prev_d;

  logic                is_fwd, is_rev, is_bad;
  logic                run_en, do_step, do_err;

  // Bit 1 carries channel A, bit 0 channel B, matching cur = {filtA, filtB}.
  assign sync = {a_sync_q[1], b_sync_q[1]};

  // Per-channel filter; INIT loads the synchronized level directly.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (state_q == ST_INIT) begin
        filt_d[i] = sync[i];
      end else if (sync[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 2'd1;
      if (init_cnt_q == 2'd2) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    is_fwd = 1'b0;
    is_rev = 1'b0;
    is_bad = 1'b0;
    case ({prev_q, filt_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: is_fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: is_rev = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: is_bad = 1'b1;
      default: ;
    endcase
  end

  assign run_en  = (state_q == ST_RUN) && enable;
  assign do_step = run_en && (is_fwd || is_rev);
  assign do_err  = run_en && is_bad;

  always_comb begin
    step_d      = do_step;
    err_d       = do_err;
    dir_d       = dir_q;
    err_count_d = err_count_q;
    if (do_step) begin
      dir_d = is_fwd;
    end
    if (do_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Period is only reported between same-direction steps with no err in between.
  always_comb begin
    cyc_d       = cyc_q;
    period_d    = period_q;
    pv_d        = pv_q;
    have_prev_d = have_prev_q;
    if (do_step) begin
      cyc_d       = '0;
      have_prev_d = 1'b1;
      if (have_prev_q && (is_fwd == dir_q)) begin
        period_d = (cyc_q == CYC_MAX) ? CYC_MAX : cyc_q + 1'b1;
        pv_d     = 1'b1;
      end else begin
        period_d = '0;
        pv_d     = 1'b0;
      end
    end else if (do_err) begin
      cyc_d       = '0;
      pv_d        = 1'b0;
      have_prev_d = 1'b0;
    end else if (run_en) begin
      if (cyc_q == CYC_MAX) begin
        period_d = CYC_MAX;
        pv_d     = 1'b0;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_q    <= '0;
      b_sync_q    <= '0;
      filt_q      <= '0;
      fcnt_q[0]   <= '0;
      fcnt_q[1]   <= '0;
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      prev_q      <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      cyc_q       <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      a_sync_q    <= {a_sync_q[0], a_in};
      b_sync_q    <= {b_sync_q[0], b_in};
      filt_q      <= filt_d;
      fcnt_q[0]   <= fcnt_d[0];
      fcnt_q[1]   <= fcnt_d[1];
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      // prev tracks even while disabled so re-enabling never yields a stale step.
      prev_q      <= filt_q;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      cyc_q       <= cyc_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign step         = step_q;
  assign dir          = dir_q;
  assign err          = err_q;
  assign err_count    = err_count_q;
  assign period       = period_q;
  assign period_valid = pv_q;

endmodule
